// File: rtl/tempsens_pkg.sv
// Shared definitions for the sensor UART frame receiver: byte-FSM states,
// bit-period derivation and frame byte order.
package tempsens_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        BREAK
    } rx_state_t;

    // Byte 0 of a frame lands in the least significant byte of the word.
    localparam bit FRAME_LSB_FIRST = 1'b1;

    function automatic int unsigned calc_clks_per_bit(input int unsigned clk_hz,
                                                      input int unsigned baud);
        return clk_hz / baud;
    endfunction

endpackage

// File: rtl/tempsens_uart_rx_byte.sv
// 8N1 byte receiver: 2-flop synchroniser, start-bit qualification, LSB-first
// data sampling and stop-bit check with a BREAK hold while the line stays low.
module tempsens_uart_rx_byte
    import tempsens_pkg::*;
#(
    parameter int CLKS_PER_BIT = 10
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rx,
    output logic [7:0] data,
    output logic       byte_done,
    output logic       stop_err,
    output logic       idle
);

    localparam int CW = $clog2(CLKS_PER_BIT + 1);
    localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);

    logic            sync1_reg;
    logic            sync2_reg;
    logic            prev_reg;
    rx_state_t       state_reg;
    logic [CW-1:0]   cnt_reg;
    logic [2:0]      bit_reg;
    logic [7:0]      shift_reg;
    logic            stop_sample;

    always_ff @(posedge clk) begin
        if (!reset) begin
            sync1_reg <= 1'b1;
            sync2_reg <= 1'b1;
            prev_reg  <= 1'b1;
            state_reg <= IDLE;
            cnt_reg   <= '0;
            bit_reg   <= '0;
            shift_reg <= '0;
        end else begin
            sync1_reg <= rx;
            sync2_reg <= sync1_reg;
            prev_reg  <= sync2_reg;
            case (state_reg)
                IDLE: begin
                    if (prev_reg && !sync2_reg) begin
                        state_reg <= START;
                        cnt_reg   <= '0;
                    end
                end
                START: begin
                    // Mid-start-bit check rejects short glitches silently.
                    if (cnt_reg == HALF_LAST) begin
                        cnt_reg   <= '0;
                        bit_reg   <= '0;
                        state_reg <= sync2_reg ? IDLE : DATA;
                    end else begin
                        cnt_reg <= cnt_reg + 1'b1;
                    end
                end
                DATA: begin
                    if (cnt_reg == BIT_LAST) begin
                        cnt_reg   <= '0;
                        shift_reg <= {sync2_reg, shift_reg[7:1]};
                        bit_reg   <= bit_reg + 1'b1;
                        if (bit_reg == 3'd7) begin
                            state_reg <= STOP;
                        end
                    end else begin
                        cnt_reg <= cnt_reg + 1'b1;
                    end
                end
                STOP: begin
                    if (cnt_reg == BIT_LAST) begin
                        cnt_reg   <= '0;
                        state_reg <= sync2_reg ? IDLE : BREAK;
                    end else begin
                        cnt_reg <= cnt_reg + 1'b1;
                    end
                end
                BREAK: begin
                    if (sync2_reg) begin
                        state_reg <= IDLE;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    // Strobes are decoded from registered state so the frame logic can act
    // on the same edge as the stop-bit sample.
    assign stop_sample = (state_reg == STOP) && (cnt_reg == BIT_LAST);
    assign byte_done   = stop_sample && sync2_reg;
    assign stop_err    = stop_sample && !sync2_reg;
    assign idle        = (state_reg == IDLE);
    assign data        = shift_reg;

endmodule

// File: rtl/tempsens_frame_rx.sv
// Host-side frame receiver: assembles NBYTES UART bytes into one word with
// valid/error strobes and an inter-byte gap timeout.
// Optional statistics counters are enabled by defining TEMPSENS_RX_STATS_EN.
module tempsens_frame_rx
    import tempsens_pkg::*;
#(
    parameter int CLK_HZ   = 10000,
    parameter int BAUD     = 1000,
    parameter int NBYTES   = 3,
    parameter int GAP_BITS = 20
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  rx,
    output logic [8*NBYTES-1:0]   frame_data,
    output logic                  frame_valid,
    output logic                  frame_err,
    output logic [1:0]            byte_idx
`ifdef TEMPSENS_RX_STATS_EN
    ,
    output logic [15:0]           frame_cnt,
    output logic [7:0]            err_cnt
`endif
);

    localparam int CLKS_PER_BIT = int'(calc_clks_per_bit(CLK_HZ, BAUD));
    localparam int GAP_LIMIT    = GAP_BITS * CLKS_PER_BIT;
    localparam int GW           = $clog2(GAP_LIMIT + 1);
    localparam logic [1:0] LAST_IDX = 2'(NBYTES - 1);
    localparam int LAST_POS     = FRAME_LSB_FIRST ? NBYTES - 1 : 0;

    logic [7:0]          rx_byte;
    logic                byte_done;
    logic                stop_err;
    logic                rx_idle;
    logic [8*NBYTES-1:0] assembled;
    logic [GW-1:0]       gap_reg;
    logic                gap_run;
    logic                gap_expire;

    tempsens_uart_rx_byte #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_byte (
        .clk       (clk),
        .reset     (reset),
        .rx        (rx),
        .data      (rx_byte),
        .byte_done (byte_done),
        .stop_err  (stop_err),
        .idle      (rx_idle)
    );

    // Earlier bytes wait in slots; the final byte is taken straight from the
    // receiver so the word is complete on the stop-bit edge.
    for (genvar gi = 0; gi < NBYTES - 1; gi++) begin : g_slot
        localparam int POS = FRAME_LSB_FIRST ? gi : NBYTES - 1 - gi;
        logic [7:0] slot_reg;

        always_ff @(posedge clk) begin
            if (!reset) begin
                slot_reg <= '0;
            end else if (byte_done && byte_idx == 2'(gi)) begin
                slot_reg <= rx_byte;
            end
        end

        assign assembled[8*POS +: 8] = slot_reg;
    end
    assign assembled[8*LAST_POS +: 8] = rx_byte;

    assign gap_run    = rx_idle && (byte_idx != 2'd0);
    assign gap_expire = gap_run && (gap_reg == GW'(GAP_LIMIT - 1));

    // Timeout is checked before the receiver leaves IDLE, so a start edge in
    // the expiry cycle begins a fresh frame at byte 0.
    always_ff @(posedge clk) begin
        if (!reset) begin
            frame_data  <= '0;
            frame_valid <= 1'b0;
            frame_err   <= 1'b0;
            byte_idx    <= 2'd0;
            gap_reg     <= '0;
        end else begin
            frame_valid <= 1'b0;
            frame_err   <= 1'b0;
            if (byte_done) begin
                gap_reg <= '0;
                if (byte_idx == LAST_IDX) begin
                    frame_data  <= assembled;
                    frame_valid <= 1'b1;
                    byte_idx    <= 2'd0;
                end else begin
                    byte_idx <= byte_idx + 2'd1;
                end
            end else if (stop_err || gap_expire) begin
                frame_err <= 1'b1;
                byte_idx  <= 2'd0;
                gap_reg   <= '0;
            end else if (gap_run) begin
                gap_reg <= gap_reg + 1'b1;
            end
        end
    end

`ifdef TEMPSENS_RX_STATS_EN
    always_ff @(posedge clk) begin
        if (!reset) begin
            frame_cnt <= '0;
            err_cnt   <= '0;
        end else begin
            if (frame_valid && frame_cnt != 16'hFFFF) begin
                frame_cnt <= frame_cnt + 16'd1;
            end
            if (frame_err && err_cnt != 8'hFF) begin
                err_cnt <= err_cnt + 8'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_tempsens_frame_rx.sv
// Self-checking bench for tempsens_frame_rx: scoreboard of expected frames
// popped on frame_valid, plus per-scenario inline checks.
module tb_tempsens_frame_rx;

    localparam int CPB = 10;
    localparam int NB  = 3;

    logic        clk   = 1'b0;
    logic        reset = 1'b0;
    logic        rx    = 1'b1;
    logic [23:0] frame_data;
    logic        frame_valid;
    logic        frame_err;
    logic [1:0]  byte_idx;
`ifdef TEMPSENS_RX_STATS_EN
    logic [15:0] frame_cnt;
    logic [7:0]  err_cnt;
`endif

    int          errors     = 0;
    int          checks     = 0;
    int          valid_seen = 0;
    int          err_seen   = 0;
    logic [23:0] exp_q[$];
    logic [23:0] exp_word;
    logic [23:0] last_frame = 24'h0;
    logic        prev_valid = 1'b0;

    tempsens_frame_rx dut (
        .clk         (clk),
        .reset       (reset),
        .rx          (rx),
        .frame_data  (frame_data),
        .frame_valid (frame_valid),
        .frame_err   (frame_err),
        .byte_idx    (byte_idx)
`ifdef TEMPSENS_RX_STATS_EN
        ,
        .frame_cnt   (frame_cnt),
        .err_cnt     (err_cnt)
`endif
    );

    always #5 clk = ~clk;

    // Scoreboard monitor: every frame_valid pops one expected word.
    always @(negedge clk) begin
        if (frame_valid === 1'b1) begin
            valid_seen++;
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL frame_unexpected actual=%h required=none", frame_data);
            end else begin
                exp_word = exp_q.pop_front();
                if (frame_data !== exp_word) begin
                    errors++;
                    $display("FAIL frame_data actual=%h required=%h", frame_data, exp_word);
                end else begin
                    $display("frame ok data=%h", frame_data);
                end
            end
            checks++;
            if (prev_valid === 1'b1 || frame_err === 1'b1) begin
                errors++;
                $display("FAIL strobe_shape actual=prev_valid:%b err:%b required=0,0",
                         prev_valid, frame_err);
            end
        end
        if (frame_err === 1'b1) begin
            err_seen++;
            $display("frame_err pulse");
        end
        prev_valid = frame_valid;
    end

    initial begin
        #3ms;
        $display("FAIL watchdog actual=timeout required=finish");
        $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
        $fatal(1, "watchdog");
    end

    task automatic send_byte(input logic [7:0] b, input logic stop);
        rx = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            repeat (CPB) @(negedge clk);
        end
        rx = stop;
        repeat (CPB) @(negedge clk);
        rx = 1'b1;
    endtask

    task automatic send_frame(input logic [23:0] w);
        exp_q.push_back(w);
        for (int k = 0; k < NB; k++) begin
            send_byte(w[8*k +: 8], 1'b1);
        end
    endtask

    task automatic idle_bits(input int n);
        rx = 1'b1;
        repeat (n * CPB) @(negedge clk);
    endtask

    task automatic wait_frames(input int target);
        for (int i = 0; i < 100 && valid_seen < target; i++) @(negedge clk);
    endtask

    task automatic test_reset();
        reset = 1'b0;
        rx    = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if (frame_data !== 24'h0) begin errors++; $display("FAIL reset_data actual=%h required=0", frame_data); end
        checks++;
        if (frame_valid !== 1'b0) begin errors++; $display("FAIL reset_valid actual=%b required=0", frame_valid); end
        checks++;
        if (frame_err !== 1'b0) begin errors++; $display("FAIL reset_err actual=%b required=0", frame_err); end
        checks++;
        if (byte_idx !== 2'd0) begin errors++; $display("FAIL reset_idx actual=%0d required=0", byte_idx); end
        reset = 1'b1;
        repeat (2) @(negedge clk);
        $display("test_reset done");
    endtask

    task automatic test_back_to_back();
        int v0;
        int e0;
        v0 = valid_seen;
        e0 = err_seen;
        exp_q.push_back(24'h123456);
        send_byte(8'h56, 1'b1);
        checks++;
        if (byte_idx !== 2'd1) begin errors++; $display("FAIL b2b_idx1 actual=%0d required=1", byte_idx); end
        send_byte(8'h34, 1'b1);
        checks++;
        if (byte_idx !== 2'd2) begin errors++; $display("FAIL b2b_idx2 actual=%0d required=2", byte_idx); end
        send_byte(8'h12, 1'b1);
        wait_frames(v0 + 1);
        checks++;
        if (valid_seen !== v0 + 1) begin errors++; $display("FAIL b2b_count actual=%0d required=%0d", valid_seen, v0 + 1); end
        checks++;
        if (err_seen !== e0) begin errors++; $display("FAIL b2b_err actual=%0d required=%0d", err_seen, e0); end
        checks++;
        if (frame_data !== 24'h123456) begin errors++; $display("FAIL b2b_hold actual=%h required=123456", frame_data); end
        checks++;
        if (byte_idx !== 2'd0) begin errors++; $display("FAIL b2b_idx0 actual=%0d required=0", byte_idx); end
        last_frame = 24'h123456;
        $display("test_back_to_back done");
    endtask

    task automatic test_glitch();
        int v0;
        int e0;
        v0 = valid_seen;
        e0 = err_seen;
        rx = 1'b0;
        repeat (3) @(negedge clk);
        rx = 1'b1;
        repeat (30) @(negedge clk);
        checks++;
        if (byte_idx !== 2'd0) begin errors++; $display("FAIL glitch_idx actual=%0d required=0", byte_idx); end
        checks++;
        if (valid_seen !== v0 || err_seen !== e0) begin
            errors++;
            $display("FAIL glitch_strobes actual=%0d/%0d required=%0d/%0d", valid_seen, err_seen, v0, e0);
        end
        $display("test_glitch done");
    endtask

    task automatic test_stop_err();
        int v0;
        int e0;
        v0 = valid_seen;
        e0 = err_seen;
        send_byte(8'h99, 1'b1);
        send_byte(8'h77, 1'b0);
        repeat (5) @(negedge clk);
        checks++;
        if (err_seen !== e0 + 1) begin errors++; $display("FAIL stoperr_count actual=%0d required=%0d", err_seen, e0 + 1); end
        checks++;
        if (byte_idx !== 2'd0) begin errors++; $display("FAIL stoperr_idx actual=%0d required=0", byte_idx); end
        checks++;
        if (frame_data !== last_frame) begin errors++; $display("FAIL stoperr_hold actual=%h required=%h", frame_data, last_frame); end
        idle_bits(2);
        send_frame(24'hABCDEF);
        wait_frames(v0 + 1);
        checks++;
        if (valid_seen !== v0 + 1) begin errors++; $display("FAIL stoperr_next actual=%0d required=%0d", valid_seen, v0 + 1); end
        checks++;
        if (frame_data !== 24'hABCDEF) begin errors++; $display("FAIL stoperr_data actual=%h required=abcdef", frame_data); end
        last_frame = 24'hABCDEF;
        $display("test_stop_err done");
    endtask

    task automatic test_timeout();
        int v0;
        int e0;
        v0 = valid_seen;
        e0 = err_seen;
        send_byte(8'h11, 1'b1);
        checks++;
        if (byte_idx !== 2'd1) begin errors++; $display("FAIL timeout_idx1 actual=%0d required=1", byte_idx); end
        idle_bits(25);
        checks++;
        if (err_seen !== e0 + 1) begin errors++; $display("FAIL timeout_count actual=%0d required=%0d", err_seen, e0 + 1); end
        checks++;
        if (byte_idx !== 2'd0) begin errors++; $display("FAIL timeout_idx0 actual=%0d required=0", byte_idx); end
        send_frame(24'h443322);
        wait_frames(v0 + 1);
        checks++;
        if (valid_seen !== v0 + 1 || err_seen !== e0 + 1) begin
            errors++;
            $display("FAIL timeout_next actual=%0d/%0d required=%0d/%0d", valid_seen, err_seen, v0 + 1, e0 + 1);
        end
        last_frame = 24'h443322;
        $display("test_timeout done");
    endtask

    task automatic test_reset_mid();
        int v0;
        send_byte(8'h55, 1'b1);
        rx = 1'b0;
        repeat (CPB) @(negedge clk);
        rx = 1'b1;
        repeat (3 * CPB) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        checks++;
        if (frame_data !== 24'h0 || frame_valid !== 1'b0 || frame_err !== 1'b0 || byte_idx !== 2'd0) begin
            errors++;
            $display("FAIL midreset_outputs actual=%h/%b/%b/%0d required=0/0/0/0",
                     frame_data, frame_valid, frame_err, byte_idx);
        end
        reset = 1'b1;
        rx    = 1'b1;
        v0    = valid_seen;
        idle_bits(3);
        send_frame(24'h030201);
        wait_frames(v0 + 1);
        checks++;
        if (frame_data !== 24'h030201) begin errors++; $display("FAIL midreset_data actual=%h required=030201", frame_data); end
        $display("test_reset_mid done");
    endtask

    task automatic test_random();
        int v0;
        v0 = valid_seen;
        for (int f = 0; f < 3; f++) begin
            send_frame(24'($urandom));
        end
        wait_frames(v0 + 3);
        checks++;
        if (valid_seen !== v0 + 3) begin errors++; $display("FAIL random_count actual=%0d required=%0d", valid_seen, v0 + 3); end
        checks++;
        if (exp_q.size() != 0) begin errors++; $display("FAIL scoreboard_left actual=%0d required=0", exp_q.size()); end
        $display("test_random done");
    endtask

`ifdef TEMPSENS_RX_STATS_EN
    task automatic test_stats();
        reset = 1'b0;
        rx    = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        send_frame(24'h123456);
        idle_bits(2);
        send_byte(8'h99, 1'b1);
        send_byte(8'h77, 1'b0);
        idle_bits(2);
        send_frame(24'hABCDEF);
        idle_bits(2);
        send_byte(8'h11, 1'b1);
        idle_bits(25);
        send_frame(24'h443322);
        idle_bits(2);
        checks++;
        if (frame_cnt !== 16'd3) begin errors++; $display("FAIL stats_frames actual=%0d required=3", frame_cnt); end
        checks++;
        if (err_cnt !== 8'd2) begin errors++; $display("FAIL stats_errs actual=%0d required=2", err_cnt); end
        for (int n = 0; n < 256; n++) begin
            send_byte(8'h00, 1'b0);
            repeat (5) @(negedge clk);
        end
        checks++;
        if (err_cnt !== 8'hFF) begin errors++; $display("FAIL stats_saturate actual=%h required=ff", err_cnt); end
        $display("test_stats done");
    endtask
`endif

    initial begin
        test_reset();
        test_back_to_back();
        test_glitch();
        test_stop_err();
        test_timeout();
        test_reset_mid();
        test_random();
`ifdef TEMPSENS_RX_STATS_EN
        test_stats();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
